// File: rtl/gb_bank_arbiter.sv
// Global-buffer SRAM port arbiter: round-robin grant over four data-type requesters,
// type-relative to absolute bank mapping, range checking and read-response routing.
module gb_bank_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 96,
  parameter int SRAM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_load,
  input  logic [3:0]      cfg_num_wei,
  input  logic [3:0]      cfg_num_flgwei,
  input  logic [3:0]      cfg_num_act,
  input  logic [3:0]      cfg_num_flgact,
  output logic            cfg_err,
  output logic            run,
  input  logic [3:0]      req_vld,
  output logic [3:0]      req_rdy,
  input  logic [3:0]      req_we,
  input  logic [15:0]     req_cor_id,
  input  logic [4*AW-1:0] req_addr,
  input  logic [4*DW-1:0] req_wdata,
  output logic            sram_en,
  output logic            sram_we,
  output logic [5:0]      sram_abs_id,
  output logic [AW-1:0]   sram_addr,
  output logic [DW-1:0]   sram_wdata,
  input  logic [DW-1:0]   sram_rdata,
  output logic [3:0]      rsp_vld,
  output logic [DW-1:0]   rsp_rdata,
  output logic            err_vld,
  output logic [1:0]      err_src
);

  localparam int unsigned LAT = SRAM_LAT;
  localparam int unsigned IW  = 2 * SRAM_LAT;
  localparam logic [LAT-1:0] HEAD = LAT'(1) << (LAT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t               state;
  logic [1:0]           ptr;
  logic [3:0][3:0]      num;
  logic [3:0][3:0]      pnd;
  logic [3:0][3:0]      cfg_cnt;
  logic [4:0]           cfg_sum;
  logic [4:0]           pnd_sum;
  logic                 gnt;
  logic [1:0]           gnt_idx;
  logic [1:0]           cand;
  logic                 grant_ok;
  logic [3:0]           sel_cor;
  logic [3:0]           sel_base;
  logic                 in_range;
  logic [1:0]           sram_src;
  logic [LAT-1:0]       pipe_v;
  logic [LAT-1:0][1:0]  pipe_idx;
  logic                 rd_issue;
  logic                 inflight;

  assign cfg_cnt = {cfg_num_flgact, cfg_num_act, cfg_num_flgwei, cfg_num_wei};
  assign cfg_sum = 5'(cfg_num_wei) + 5'(cfg_num_flgwei) + 5'(cfg_num_act) + 5'(cfg_num_flgact);
  assign pnd_sum = 5'(pnd[0]) + 5'(pnd[1]) + 5'(pnd[2]) + 5'(pnd[3]);
  assign run     = (state == RUN);

  always_comb begin
    gnt     = 1'b0;
    gnt_idx = ptr;
    cand    = ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr + i[1:0];
      if (!gnt && req_vld[cand]) begin
        gnt     = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Grants stop in the cfg_load cycle itself so no access slips in ahead of a reconfig.
  assign grant_ok = (state == RUN) && !cfg_load && gnt;
  assign req_rdy  = grant_ok ? (4'b0001 << gnt_idx) : '0;
  assign sel_cor  = req_cor_id[gnt_idx*4 +: 4];
  assign in_range = sel_cor < num[gnt_idx];

  always_comb begin
    case (gnt_idx)
      2'd0:    sel_base = '0;
      2'd1:    sel_base = num[0];
      2'd2:    sel_base = num[0] + num[1];
      default: sel_base = num[0] + num[1] + num[2];
    endcase
  end

  // Head stage is delivering its data this cycle, so it no longer holds off the drain.
  assign rd_issue = sram_en && !sram_we;
  assign inflight = rd_issue || (|(pipe_v & ~HEAD));

  assign rsp_vld   = pipe_v[LAT-1] ? (4'b0001 << pipe_idx[LAT-1]) : '0;
  assign rsp_rdata = pipe_v[LAT-1] ? sram_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      num         <= '0;
      pnd         <= '0;
      cfg_err     <= 1'b0;
      err_vld     <= 1'b0;
      err_src     <= '0;
      sram_en     <= 1'b0;
      sram_we     <= 1'b0;
      sram_abs_id <= '0;
      sram_addr   <= '0;
      sram_wdata  <= '0;
      sram_src    <= '0;
      pipe_v      <= '0;
      pipe_idx    <= '0;
    end else begin
      cfg_err  <= 1'b0;
      err_vld  <= 1'b0;
      sram_en  <= 1'b0;
      sram_we  <= 1'b0;
      pipe_v   <= LAT'({pipe_v, rd_issue});
      pipe_idx <= IW'({pipe_idx, sram_src});
      case (state)
        IDLE: begin
          if (cfg_load) begin
            if (cfg_sum <= 5'd16) begin
              num   <= cfg_cnt;
              state <= RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (cfg_load) begin
            pnd   <= cfg_cnt;
            state <= DRAIN;
          end else if (grant_ok) begin
            ptr <= gnt_idx + 2'd1;
            if (in_range) begin
              sram_en     <= 1'b1;
              sram_we     <= req_we[gnt_idx];
              sram_abs_id <= {gnt_idx, sel_base + sel_cor};
              sram_addr   <= req_addr[gnt_idx*AW +: AW];
              sram_wdata  <= req_wdata[gnt_idx*DW +: DW];
              sram_src    <= gnt_idx;
            end else begin
              err_vld <= 1'b1;
              err_src <= gnt_idx;
            end
          end
        end
        DRAIN: begin
          if (cfg_load) begin
            pnd <= cfg_cnt;
          end else if (!inflight) begin
            if (pnd_sum <= 5'd16) begin
              num   <= pnd;
              state <= RUN;
            end else begin
              cfg_err <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gb_bank_arbiter.sv
// Scoreboard bench for gb_bank_arbiter: one instance at SRAM_LAT=1 and one at SRAM_LAT=3
// share stimulus; expectations come from a small reference model of grant and bank mapping.
module tb_gb_bank_arbiter;
  localparam int AW = 10;
  localparam int DW = 96;

  typedef struct packed {
    int           due;
    logic [127:0] val;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, cfg_load;
  logic [3:0]      cfg_wei, cfg_fw, cfg_act, cfg_fa;
  logic [3:0]      req_vld, req_we;
  logic [15:0]     req_cor_id;
  logic [4*AW-1:0] req_addr;
  logic [4*DW-1:0] req_wdata;

  logic cfg_err, run, sram_en, sram_we, err_vld;
  logic [3:0] req_rdy, rsp_vld;
  logic [5:0] sram_abs_id;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata, rsp_rdata;
  logic [1:0] err_src;

  logic cfg_err3, run3, sram_en3, sram_we3, err_vld3;
  logic [3:0] req_rdy3, rsp_vld3;
  logic [5:0] sram_abs_id3;
  logic [AW-1:0] sram_addr3;
  logic [DW-1:0] sram_wdata3, sram_rdata3, rsp_rdata3;
  logic [1:0] err_src3;

  gb_bank_arbiter #(.AW(AW), .DW(DW), .SRAM_LAT(1)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load),
    .cfg_num_wei(cfg_wei), .cfg_num_flgwei(cfg_fw), .cfg_num_act(cfg_act), .cfg_num_flgact(cfg_fa),
    .cfg_err(cfg_err), .run(run), .req_vld(req_vld), .req_rdy(req_rdy), .req_we(req_we),
    .req_cor_id(req_cor_id), .req_addr(req_addr), .req_wdata(req_wdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_abs_id(sram_abs_id), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata),
    .err_vld(err_vld), .err_src(err_src));

  gb_bank_arbiter #(.AW(AW), .DW(DW), .SRAM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .cfg_load(cfg_load),
    .cfg_num_wei(cfg_wei), .cfg_num_flgwei(cfg_fw), .cfg_num_act(cfg_act), .cfg_num_flgact(cfg_fa),
    .cfg_err(cfg_err3), .run(run3), .req_vld(req_vld), .req_rdy(req_rdy3), .req_we(req_we),
    .req_cor_id(req_cor_id), .req_addr(req_addr), .req_wdata(req_wdata),
    .sram_en(sram_en3), .sram_we(sram_we3), .sram_abs_id(sram_abs_id3), .sram_addr(sram_addr3),
    .sram_wdata(sram_wdata3), .sram_rdata(sram_rdata3), .rsp_vld(rsp_vld3), .rsp_rdata(rsp_rdata3),
    .err_vld(err_vld3), .err_src(err_src3));

  // SRAM models: read data is a pattern derived from bank and address.
  function automatic logic [DW-1:0] rd_pat(input logic [5:0] id, input logic [AW-1:0] a);
    return {6{id, a}};
  endfunction

  logic [DW-1:0] p3 [3];
  always @(posedge clk) begin
    sram_rdata <= (sram_en && !sram_we) ? rd_pat(sram_abs_id, sram_addr) : '0;
    p3[0] <= (sram_en3 && !sram_we3) ? rd_pat(sram_abs_id3, sram_addr3) : '0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign sram_rdata3 = p3[2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  ent_t cmd_q[$], rsp_q[$], rsp3_q[$], err_q[$], cfe_q[$];
  logic m_run, m_run3;
  logic [1:0] m_ptr;
  logic [3:0] m_num [4];
  logic [3:0] m_last;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ent_t mk(input int due, input logic [127:0] v);
    ent_t e;
    e.due = due;
    e.val = v;
    return e;
  endfunction

  function automatic logic [5:0] exp_abs(input logic [1:0] t, input logic [3:0] cor);
    logic [4:0] b;
    b = '0;
    for (int k = 0; k < 4; k++) if (k < int'(t)) b += 5'(m_num[k]);
    return {t, b[3:0] + cor};
  endfunction

  task automatic model_grant(input logic [1:0] idx, input logic three);
    logic [3:0] cor;
    logic [5:0] abs_id;
    logic [AW-1:0] a;
    cor = req_cor_id[idx*4 +: 4];
    a   = req_addr[idx*AW +: AW];
    if (cor >= m_num[idx]) begin
      if (!three) err_q.push_back(mk(cyc + 1, {125'b0, 1'b1, idx}));
    end else begin
      abs_id = exp_abs(idx, cor);
      if (!three)
        cmd_q.push_back(mk(cyc + 1, {15'b0, req_we[idx], abs_id, a, req_wdata[idx*DW +: DW]}));
      if (!req_we[idx]) begin
        if (three) rsp3_q.push_back(mk(cyc + 4, {28'b0, 4'b0001 << idx, rd_pat(abs_id, a)}));
        else       rsp_q.push_back(mk(cyc + 2, {28'b0, 4'b0001 << idx, rd_pat(abs_id, a)}));
      end
    end
  endtask

  task automatic monitor();
    ent_t e;
    logic [127:0] exp;
    if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
      e = cmd_q.pop_front();
      check("sram_en", {127'b0, sram_en}, 128'd1);
      check("sram_cmd", {15'b0, sram_we, sram_abs_id, sram_addr, sram_wdata}, e.val);
    end else begin
      check("sram_en", {127'b0, sram_en}, '0);
    end
    exp = '0;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin e = rsp_q.pop_front(); exp = e.val; end
    check("rsp", {28'b0, rsp_vld, rsp_rdata}, exp);
    exp = '0;
    if (rsp3_q.size() > 0 && rsp3_q[0].due == cyc) begin e = rsp3_q.pop_front(); exp = e.val; end
    check("rsp3", {28'b0, rsp_vld3, rsp_rdata3}, exp);
    exp = '0;
    if (err_q.size() > 0 && err_q[0].due == cyc) begin e = err_q.pop_front(); exp = e.val; end
    check("err", {125'b0, err_vld, err_vld ? err_src : 2'b00}, exp);
    exp = '0;
    if (cfe_q.size() > 0 && cfe_q[0].due == cyc) begin e = cfe_q.pop_front(); exp = 128'd1; end
    check("cfg_err", {127'b0, cfg_err}, exp);
  endtask

  task automatic clk_step();
    logic found;
    logic [1:0] idx, c;
    logic [3:0] erdy, erdy3;
    #1;
    found = 1'b0;
    idx = m_ptr;
    for (int i = 0; i < 4; i++) begin
      c = m_ptr + 2'(i);
      if (!found && req_vld[c]) begin found = 1'b1; idx = c; end
    end
    erdy  = (m_run  && !cfg_load && found) ? (4'b0001 << idx) : 4'b0000;
    erdy3 = (m_run3 && !cfg_load && found) ? (4'b0001 << idx) : 4'b0000;
    check("req_rdy", {124'b0, req_rdy}, {124'b0, erdy});
    check("req_rdy3", {124'b0, req_rdy3}, {124'b0, erdy3});
    check("run", {127'b0, run}, {127'b0, m_run});
    check("run3", {127'b0, run3}, {127'b0, m_run3});
    m_last = erdy;
    if (erdy != 4'b0000) begin
      model_grant(idx, 1'b0);
      m_ptr = idx + 2'd1;
    end
    if (erdy3 != 4'b0000) model_grant(idx, 1'b1);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic set_cfg(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    cfg_wei = a; cfg_fw = b; cfg_act = c; cfg_fa = d;
  endtask

  task automatic apply_num();
    m_num[0] = cfg_wei; m_num[1] = cfg_fw; m_num[2] = cfg_act; m_num[3] = cfg_fa;
  endtask

  task automatic set_req(input int i, input logic we, input logic [3:0] cor,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[i] = we;
    req_cor_id[i*4 +: 4] = cor;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic cfg_from_idle(input logic ok);
    cfg_load = 1'b1;
    if (!ok) cfe_q.push_back(mk(cyc + 1, 128'd1));
    clk_step();
    cfg_load = 1'b0;
    if (ok) begin
      apply_num();
      m_run = 1'b1;
      m_run3 = 1'b1;
    end
  endtask

  task automatic do_reset();
    while (rsp3_q.size() > 0 && rsp3_q[rsp3_q.size()-1].due > cyc) void'(rsp3_q.pop_back());
    while (rsp_q.size() > 0 && rsp_q[rsp_q.size()-1].due > cyc) void'(rsp_q.pop_back());
    rst = 1'b1;
    m_run = 1'b0;
    m_run3 = 1'b0;
    clk_step();
    rst = 1'b0;
    m_ptr = '0;
    for (int k = 0; k < 4; k++) m_num[k] = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; cfg_load = 1'b0; set_cfg(4'd0, 4'd0, 4'd0, 4'd0);
    req_vld = '0; req_we = '0; req_cor_id = '0; req_addr = '0; req_wdata = '0;
    m_run = 1'b0; m_run3 = 1'b0; m_ptr = '0; m_last = '0;
    for (int k = 0; k < 4; k++) m_num[k] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    monitor();
    check("rst_run", {127'b0, run}, '0);
    clk_step();

    // Oversubscribed config from IDLE
    set_cfg(4'd8, 4'd4, 4'd4, 4'd1);
    cfg_from_idle(1'b0);
    req_vld = 4'hF;
    clk_step();
    req_vld = '0;

    set_cfg(4'd4, 4'd2, 4'd6, 4'd2);
    cfg_from_idle(1'b1);

    // act read cor 3 -> bank 9
    set_req(2, 1'b0, 4'd3, 10'h155, {3{32'hA5A5_0001}});
    req_vld = 4'b0100;
    clk_step();
    check("abs_act", {122'b0, sram_abs_id}, 128'h29);
    req_vld = '0;
    repeat (2) clk_step();

    // flgact write cor 1 -> bank 13
    set_req(3, 1'b1, 4'd1, 10'h0AA, {3{32'h1234_5678}});
    req_vld = 4'b1000;
    clk_step();
    check("abs_flgact", {121'b0, sram_we, sram_abs_id}, {121'b0, 1'b1, 6'h3D});
    req_vld = '0;
    repeat (2) clk_step();

    // All requesters held: grants rotate 0,1,2,3,0
    set_req(0, 1'b0, 4'd3, 10'h011, {3{32'h0000_0011}});
    set_req(1, 1'b1, 4'd1, 10'h022, {3{32'h0000_0022}});
    set_req(2, 1'b0, 4'd5, 10'h033, {3{32'h0000_0033}});
    set_req(3, 1'b0, 4'd0, 10'h044, {3{32'h0000_0044}});
    req_vld = 4'hF;
    repeat (5) clk_step();
    req_vld = '0;
    repeat (2) clk_step();

    // wei cor_id == num_wei is out of range
    set_req(0, 1'b0, 4'd4, 10'h3FF, '0);
    req_vld = 4'b0001;
    clk_step();
    req_vld = '0;
    repeat (2) clk_step();

    // Random traffic; each requester holds its fields until granted
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_vld[i] || m_last[i]) begin
          req_vld[i] = 1'($urandom_range(0, 1));
          set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), AW'($urandom),
                  {$urandom, $urandom, $urandom});
        end
      end
      clk_step();
    end
    req_vld = '0;
    repeat (5) clk_step();

    // Reconfig with a read in flight: drain length follows SRAM_LAT
    set_req(2, 1'b0, 4'd2, 10'h2C3, '0);
    req_vld = 4'b0100;
    clk_step();
    req_vld = '0;
    set_cfg(4'd3, 4'd3, 4'd3, 4'd3);
    cfg_load = 1'b1;
    clk_step();
    cfg_load = 1'b0;
    m_run = 1'b0; m_run3 = 1'b0;
    clk_step();
    m_run = 1'b1;
    apply_num();
    repeat (2) clk_step();
    m_run3 = 1'b1;
    clk_step();
    set_req(2, 1'b0, 4'd2, 10'h101, '0);
    req_vld = 4'b0100;
    clk_step();
    check("abs_newcfg", {122'b0, sram_abs_id}, 128'h28);
    req_vld = '0;
    repeat (4) clk_step();

    // Invalid pending config applied after drain -> cfg_err, back to IDLE
    set_req(2, 1'b0, 4'd0, 10'h077, '0);
    req_vld = 4'b0100;
    clk_step();
    req_vld = '0;
    set_cfg(4'd8, 4'd4, 4'd4, 4'd1);
    cfg_load = 1'b1;
    clk_step();
    cfg_load = 1'b0;
    m_run = 1'b0; m_run3 = 1'b0;
    cfe_q.push_back(mk(cyc + 1, 128'd1));
    repeat (6) clk_step();

    // Reset during drain: dut3's in-flight read must never come back
    set_cfg(4'd4, 4'd2, 4'd6, 4'd2);
    cfg_from_idle(1'b1);
    set_req(2, 1'b0, 4'd1, 10'h0F0, '0);
    req_vld = 4'b0100;
    clk_step();
    req_vld = '0;
    cfg_load = 1'b1;
    clk_step();
    cfg_load = 1'b0;
    m_run = 1'b0; m_run3 = 1'b0;
    do_reset();
    repeat (5) clk_step();

    check("sb_empty", 128'(cmd_q.size() + rsp_q.size() + rsp3_q.size() + err_q.size() + cfe_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gb_bank_arbiter.md
# gb_bank_arbiter

Shares the single global-buffer SRAM access port among the four data-type requesters: weight, weight flag, activation and activation flag. It grants one request per cycle round-robin and converts each requester's type-relative bank ID into an absolute 6-bit bank ID using the configured per-type bank counts. It range-checks every request and routes read data back to the originating requester. It sits between the GB read/write engines and the SRAM bank array.

## Interface
Parameters:
- AW, 10, SRAM word address width
- DW, 96, SRAM data width
- SRAM_LAT, 1, cycles from sram_en (read) to valid sram_rdata; legal range 1..4

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- cfg_load  in  1  load-config strobe
- cfg_num_wei, cfg_num_flgwei, cfg_num_act, cfg_num_flgact  in  4 each  bank counts per type
- cfg_err  out  1  one-cycle pulse: rejected config (sum > 16)
- run  out  1  high while in RUN
- req_vld  in  4  request valid; bit0 wei, bit1 flgwei, bit2 act, bit3 flgact
- req_rdy  out  4  request accepted (one-hot or zero)
- req_we  in  4  1 = write, 0 = read, per requester
- req_cor_id  in  16  type-relative bank ID, 4 bits per requester, packed [4i+3:4i]
- req_addr  in  4*AW  word address per requester
- req_wdata  in  4*DW  write data per requester
- sram_en, sram_we  out  1 each  SRAM command strobe / write enable
- sram_abs_id  out  6  absolute bank ID {type[1:0], bank[3:0]}
- sram_addr  out  AW; sram_wdata  out  DW
- sram_rdata  in  DW  read data
- rsp_vld  out  4  read response valid, one-hot
- rsp_rdata  out  DW  read data to requester
- err_vld  out  1  one-cycle pulse: out-of-range request dropped
- err_src  out  2  requester index of the error

## Operation
- States:
  - IDLE: unconfigured; req_rdy = 0.
  - RUN: arbitrating.
  - DRAIN: reconfig pending; req_rdy = 0.
- IDLE + cfg_load:
  - Compute 5-bit sum of the four counts.
  - If sum ≤ 16, latch the counts and go to RUN next cycle.
  - Otherwise, pulse cfg_err next cycle and stay in IDLE.
- RUN + cfg_load: latch the counts into a pending set and go to DRAIN.
- DRAIN:
  - Grants stop immediately, including in the cfg_load cycle itself.
  - Once no read is in flight, apply the pending set after the same sum check. Valid: go to RUN. Invalid: cfg_err, go to IDLE.
  - cfg_load during DRAIN overwrites the pending set.
- Bases: wei = 0; flgwei = num_wei; act = num_wei + num_flgwei; flgact = act base + num_act.
- Type tags:
  - wei 2'b00, flgwei 2'b01, act 2'b10, flgact 2'b11.
  - bank = base + cor_id, computed 5-bit and truncated to 4 bits. No overflow is possible because of the range check and sum ≤ 16.
- Arbitration:
  - A 2-bit pointer ptr (reset 0) selects the first requester with req_vld among ptr, ptr+1, ... (mod 4). That requester gets req_rdy.
  - On a grant, ptr becomes granted+1 (mod 4).
  - req_rdy is combinational from req_vld and state. Requesters must hold all fields stable until vld & rdy.
- Range check:
  - If cor_id ≥ num of its type (including num = 0), the request is still consumed (rdy = 1).
  - No SRAM access is issued; err_vld/err_src pulse next cycle.
- Read responses: a requester index plus valid travels a SRAM_LAT-deep shift register. rsp_vld[idx] = 1 and rsp_rdata = sram_rdata in the cycle the data is valid.
- Writes produce no response.
- rsp_rdata is 0 when no rsp_vld bit is set.

## Timing
- Handshake in cycle T → sram_en/we/abs_id/addr/wdata registered, valid in T+1 for exactly one cycle.
- Read issued in T+1 → rsp_vld in T+1+SRAM_LAT.
- Throughput: one access per cycle, back-to-back.
- Reset (any state, mid-read included) → next cycle:
  - state IDLE; ptr 0; counts 0.
  - Response pipeline cleared; in-flight reads are never returned.
  - All outputs 0.
- A grant and a response to the same or another requester in the same cycle are independent.
- cfg_err and err_vld may be high in the same cycle.

## Test plan
- Reset, then cfg 4/2/6/2, act read cor_id 3 → sram_abs_id = 6'h29 (10_1001) at T+1; rsp_vld = 4'b0100 at T+2 (SRAM_LAT = 1).
- Same cfg, flgact write cor_id 1 → sram_abs_id = 6'h3D, sram_we = 1, no rsp_vld.
- All four req_vld held high from ptr = 0 → grants in order 0,1,2,3,0 on consecutive cycles; sram_en high continuously.
- wei request cor_id 4 with num_wei = 4 → req_rdy = 1, sram_en stays 0, err_vld = 1 and err_src = 0 the next cycle.
- cfg 8/4/4/1 (sum 17) in IDLE → cfg_err pulse, run stays 0, req_rdy = 0.
- SRAM_LAT = 3, read in flight, cfg_load (valid) → req_rdy = 0 from the cfg_load cycle; DRAIN until rsp_vld is delivered; run reasserts the cycle after the drain completes. Repeat with rst during the drain → no rsp_vld, state IDLE.
